// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the PISO serial transmitter.
// Holds the FSM state type, default geometry and the counter-width helper.
package piso_tx_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } tx_state_e;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_BIT_PERIOD = 1;

   // Bits needed to hold values 0..value-1; never less than one bit.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r++;
      end
      if (r < 1) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bit_period_timer.sv
// Modulo-BIT_PERIOD counter; tick marks the last cycle of a bit period and
// tick_next is the same decode one cycle early so the caller can register it.
module bit_period_timer
   import piso_tx_pkg::*;
#(
   parameter int BIT_PERIOD = DEF_BIT_PERIOD
) (
   input  logic clk,
   input  logic clear,
   input  logic run,
   output logic tick,
   output logic tick_next
);

   generate
      if (BIT_PERIOD == 1) begin : g_const
         // Every cycle ends a bit period; no counter state needed.
         logic unused_inputs;
         assign unused_inputs = ^{clk, clear, run};
         assign tick          = 1'b1;
         assign tick_next     = 1'b1;
      end else begin : g_count
         localparam int            CW   = clog2(BIT_PERIOD);
         localparam logic [CW-1:0] LAST = CW'(BIT_PERIOD - 1);

         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;

         // Idle holds the counter at zero so a new frame always starts aligned.
         always_comb begin
            cnt_d = '0;
            if (run) begin
               cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk or negedge clear) begin
            if (!clear) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign tick      = (cnt_q == LAST);
         assign tick_next = (cnt_d == LAST);
      end
   endgenerate

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter, MSB first, one shift_out strobe per bit.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a new word; serial_out and shift_out held low
// SHIFT | frame in progress; one bit per BIT_PERIOD cycles
module piso_serial_tx
   import piso_tx_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int BIT_PERIOD = DEF_BIT_PERIOD
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             serial_out,
   output logic             shift_out,
   output logic             busy,
   output logic             done
);

`ifdef PISO_TX_PARITY_EN
   localparam int FRAME_W = WIDTH + 1;
`else
   localparam int FRAME_W = WIDTH;
`endif
   localparam int                 BCW      = clog2(FRAME_W);
   localparam logic [BCW-1:0]     LAST_BIT = BCW'(FRAME_W - 1);

   tx_state_e          state_q;
   tx_state_e          state_d;
   logic [FRAME_W-1:0] shreg_q;
   logic [FRAME_W-1:0] shreg_d;
   logic [FRAME_W-1:0] frame_word;
   logic [BCW-1:0]     bit_cnt_q;
   logic [BCW-1:0]     bit_cnt_d;
   logic               busy_d;
   logic               shift_d;
   logic               done_d;
   logic               tick;
   logic               tick_next;

`ifdef PISO_TX_PARITY_EN
   assign frame_word = {data_in, ^data_in};
`else
   assign frame_word = data_in;
`endif

   bit_period_timer #(
      .BIT_PERIOD (BIT_PERIOD)
   ) u_timer (
      .clk       (clk),
      .clear     (clear),
      .run       (state_q == SHIFT),
      .tick      (tick),
      .tick_next (tick_next)
   );

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               shreg_d   = frame_word;
               bit_cnt_d = LAST_BIT;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               // Zero fill leaves the register empty, so serial_out idles low.
               shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
               if (bit_cnt_q == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q - 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d  = (state_d == SHIFT);
      shift_d = busy_d & tick_next;
   end

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         busy      <= 1'b0;
         shift_out <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         busy      <= busy_d;
         shift_out <= shift_d;
         done      <= done_d;
      end
   end

   assign serial_out = shreg_q[FRAME_W-1];
   assign ready      = (state_q == IDLE);

endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed bench for piso_serial_tx: one instance at BIT_PERIOD=1, one at 3.
// Honours PISO_TX_PARITY_EN when compiled with it.
module tb_piso_serial_tx;

`ifdef PISO_TX_PARITY_EN
   localparam int FW = 9;
`else
   localparam int FW = 8;
`endif

   logic       clk = 1'b0;
   logic       clear;
   logic [7:0] data1, data3;
   logic       load1, load3;
   logic       ready1, ser1, sh1, busy1, done1;
   logic       ready3, ser3, sh3, busy3, done3;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   piso_serial_tx #(.WIDTH(8), .BIT_PERIOD(1)) dut1 (
      .clk(clk), .clear(clear), .data_in(data1), .load(load1), .ready(ready1),
      .serial_out(ser1), .shift_out(sh1), .busy(busy1), .done(done1)
   );

   piso_serial_tx #(.WIDTH(8), .BIT_PERIOD(3)) dut3 (
      .clk(clk), .clear(clear), .data_in(data3), .load(load3), .ready(ready3),
      .serial_out(ser3), .shift_out(sh3), .busy(busy3), .done(done3)
   );

   function automatic logic [FW-1:0] frame_of(input logic [7:0] d);
`ifdef PISO_TX_PARITY_EN
      return {d, ^d};
`else
      return d;
`endif
   endfunction

   // Called at a negedge; returns at the negedge of cycle 1.
   task automatic start1(input logic [7:0] d);
      load1 = 1'b1; data1 = d;
      @(negedge clk);
      load1 = 1'b0; data1 = 8'($urandom);
   endtask

   task automatic start3(input logic [7:0] d);
      load3 = 1'b1; data3 = d;
      @(negedge clk);
      load3 = 1'b0; data3 = 8'($urandom);
   endtask

   task automatic test_reset();
      checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready1); end
      checks++; if (ser1 !== 1'b0) begin errors++; $display("FAIL reset_serial: got %b expected 0", ser1); end
      checks++; if (sh1 !== 1'b0) begin errors++; $display("FAIL reset_shift: got %b expected 0", sh1); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
      checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done1); end
      checks++; if ({ready3, ser3, sh3, busy3, done3} !== 5'b10000) begin errors++; $display("FAIL reset_dut3: got %b expected 10000", {ready3, ser3, sh3, busy3, done3}); end
   endtask

   task automatic test_basic();
      logic [FW-1:0] fr;
      logic [FW-1:0] rx;
      fr = frame_of(8'hA5);
      rx = '0;
      start1(8'hA5);
      for (int c = 1; c <= FW; c++) begin
         checks++; if (ser1 !== fr[FW-c]) begin errors++; $display("FAIL basic_serial c%0d: got %b expected %b", c, ser1, fr[FW-c]); end
         checks++; if (sh1 !== 1'b1) begin errors++; $display("FAIL basic_strobe c%0d: got %b expected 1", c, sh1); end
         checks++; if (busy1 !== 1'b1 || ready1 !== 1'b0) begin errors++; $display("FAIL basic_busy c%0d: got busy=%b ready=%b expected 1/0", c, busy1, ready1); end
         if (sh1) rx = {rx[FW-2:0], ser1};
         @(negedge clk);
      end
      checks++; if ({done1, busy1, ready1, sh1, ser1} !== 5'b10100) begin errors++; $display("FAIL basic_done: got %b expected 10100", {done1, busy1, ready1, sh1, ser1}); end
      checks++; if (rx !== fr) begin errors++; $display("FAIL basic_rx: got %h expected %h", rx, fr); end
      @(negedge clk);
      checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done1); end
   endtask

   task automatic test_period3();
      logic [FW-1:0] fr;
      logic [FW-1:0] rx;
      int            strobes;
      fr = frame_of(8'h81);
      rx = '0;
      strobes = 0;
      start3(8'h81);
      for (int c = 1; c <= FW * 3; c++) begin
         checks++; if (ser3 !== fr[FW-1-(c-1)/3]) begin errors++; $display("FAIL p3_serial c%0d: got %b expected %b", c, ser3, fr[FW-1-(c-1)/3]); end
         checks++; if (sh3 !== ((c % 3) == 0)) begin errors++; $display("FAIL p3_strobe c%0d: got %b expected %b", c, sh3, (c % 3) == 0); end
         checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL p3_early_done c%0d: got %b expected 0", c, done3); end
         if (sh3) begin
            rx = {rx[FW-2:0], ser3};
            strobes++;
         end
         @(negedge clk);
      end
      checks++; if ({done3, busy3, ready3, sh3, ser3} !== 5'b10100) begin errors++; $display("FAIL p3_done: got %b expected 10100", {done3, busy3, ready3, sh3, ser3}); end
      checks++; if (rx !== fr) begin errors++; $display("FAIL p3_rx: got %h expected %h", rx, fr); end
      checks++; if (strobes !== FW) begin errors++; $display("FAIL p3_strobes: got %0d expected %0d", strobes, FW); end
      @(negedge clk);
   endtask

   task automatic test_busy_reject();
      logic [FW-1:0] rx;
      int            strobes;
      int            dones;
      rx = '0;
      strobes = 0;
      dones = 0;
      start3(8'hFF);
      for (int c = 1; c <= FW * 3 + 4; c++) begin
         load3 = (c == 4);
         data3 = 8'h00;
         if (sh3) begin
            rx = {rx[FW-2:0], ser3};
            strobes++;
         end
         if (done3) dones++;
         @(negedge clk);
      end
      load3 = 1'b0;
      checks++; if (rx !== frame_of(8'hFF)) begin errors++; $display("FAIL reject_rx: got %h expected %h", rx, frame_of(8'hFF)); end
      checks++; if (strobes !== FW) begin errors++; $display("FAIL reject_strobes: got %0d expected %0d", strobes, FW); end
      checks++; if (dones !== 1) begin errors++; $display("FAIL reject_dones: got %0d expected 1", dones); end
      checks++; if (busy3 !== 1'b0 || ready3 !== 1'b1) begin errors++; $display("FAIL reject_idle: got busy=%b ready=%b expected 0/1", busy3, ready3); end
   endtask

   task automatic test_back_to_back();
      logic [FW-1:0] rx;
      logic [FW-1:0] fr;
      rx = '0;
      fr = frame_of(8'h0F);
      start1(8'h0F);
      for (int c = 1; c <= FW; c++) begin
         checks++; if (ser1 !== fr[FW-c]) begin errors++; $display("FAIL b2b_serial_a c%0d: got %b expected %b", c, ser1, fr[FW-c]); end
         if (sh1) rx = {rx[FW-2:0], ser1};
         @(negedge clk);
      end
      checks++; if (rx !== fr) begin errors++; $display("FAIL b2b_rx_a: got %h expected %h", rx, fr); end
      checks++; if ({done1, ready1, sh1} !== 3'b110) begin errors++; $display("FAIL b2b_gap: got %b expected 110", {done1, ready1, sh1}); end
      fr = frame_of(8'hF0);
      start1(8'hF0);
      for (int c = 1; c <= FW; c++) begin
         checks++; if (ser1 !== fr[FW-c] || sh1 !== 1'b1) begin errors++; $display("FAIL b2b_serial_b c%0d: got ser=%b sh=%b expected %b/1", c, ser1, sh1, fr[FW-c]); end
         if (sh1) rx = {rx[FW-2:0], ser1};
         @(negedge clk);
      end
      checks++; if (rx !== fr) begin errors++; $display("FAIL b2b_rx_b: got %h expected %h", rx, fr); end
      checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL b2b_done_b: got %b expected 1", done1); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [FW-1:0] rx;
      logic [FW-1:0] fr;
      rx = '0;
      start1(8'hA5);
      @(negedge clk);
      @(negedge clk);
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy1); end
      clear = 1'b0;
      #1;
      checks++; if ({ser1, sh1, busy1, done1} !== 4'b0000) begin errors++; $display("FAIL mid_abort: got %b expected 0000", {ser1, sh1, busy1, done1}); end
      checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", ready1); end
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      checks++; if ({ready1, busy1, done1, sh1} !== 4'b1000) begin errors++; $display("FAIL mid_after_release: got %b expected 1000", {ready1, busy1, done1, sh1}); end
      fr = frame_of(8'h3C);
      start1(8'h3C);
      for (int c = 1; c <= FW; c++) begin
         if (sh1) rx = {rx[FW-2:0], ser1};
         @(negedge clk);
      end
      checks++; if (rx !== fr) begin errors++; $display("FAIL mid_rx: got %h expected %h", rx, fr); end
      checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL mid_done: got %b expected 1", done1); end
      @(negedge clk);
   endtask

`ifdef PISO_TX_PARITY_EN
   task automatic test_parity();
      logic [8:0] rx;
      rx = '0;
      start1(8'h07);
      for (int c = 1; c <= 9; c++) begin
         if (sh1) rx = {rx[7:0], ser1};
         @(negedge clk);
      end
      checks++; if (rx !== 9'h00F) begin errors++; $display("FAIL parity_07: got %h expected 00f", rx); end
      checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL parity_done: got %b expected 1", done1); end
      @(negedge clk);
      rx = '0;
      start1(8'h03);
      for (int c = 1; c <= 9; c++) begin
         if (sh1) rx = {rx[7:0], ser1};
         @(negedge clk);
      end
      checks++; if (rx !== 9'h006) begin errors++; $display("FAIL parity_03: got %h expected 006", rx); end
      @(negedge clk);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear = 1'b0;
      load1 = 1'b0; load3 = 1'b0;
      data1 = 8'h00; data3 = 8'h00;
      @(negedge clk);
      @(negedge clk);
      test_reset();
      clear = 1'b1;
      @(negedge clk);
      test_basic();
      test_period3();
      test_busy_reject();
      test_back_to_back();
      test_reset_mid();
`ifdef PISO_TX_PARITY_EN
      test_parity();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/piso_serial_tx.md
Name: piso_serial_tx

Overview:
- Parallel-in/serial-out transmitter. It is the sending end of the team's 8-bit serial-in shift register link.
- Accepts a parallel word through a valid/ready handshake and shifts it out MSB-first on serial_out.
- Emits a one-cycle shift_out strobe per bit. shift_out drives the receiver's shift input; serial_out drives its serial_in.
- After WIDTH strobes, the receiver's parallel output equals the transmitted word.

Parameters:
- WIDTH, 8: data word width in bits (>=2).
- BIT_PERIOD, 1: clock cycles per transmitted bit (>=1).

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  parallel word to transmit; sampled only on an accepted load.
- load  input  1  request to transmit data_in (valid).
- ready  output  1  high when a load will be accepted this cycle.
- serial_out  output  1  current serial bit, MSB first.
- shift_out  output  1  one-cycle strobe; the receiver captures serial_out on the rising edge that ends this cycle.
- busy  output  1  high while a word is being shifted.
- done  output  1  one-cycle pulse after the last bit's strobe.

Behaviour:
- Reset (clear low, asynchronous): state IDLE, shift register 0, counters 0. Outputs: serial_out=0, shift_out=0, busy=0, done=0, ready=1.
- All outputs are registered, except ready, which is decoded from state (ready = state==IDLE).
- States:
  - IDLE: ready=1. On load && ready at edge N, capture data_in into the shift register, set bit_cnt=WIDTH-1 and period_cnt=0, and go to SHIFT.
  - SHIFT: busy=1. period_cnt counts 0..BIT_PERIOD-1. When period_cnt==BIT_PERIOD-1: shift_out is high for that cycle; at the next edge, the shift register shifts left by one and period_cnt wraps to 0. If bit_cnt==0 at that point, go to IDLE; otherwise decrement bit_cnt.
- Timing. Cycle 1 is the cycle after acceptance edge N.
  - Bit i (i=0 is the MSB) is on serial_out during cycles i*BIT_PERIOD+1 .. (i+1)*BIT_PERIOD.
  - shift_out is high only in cycle (i+1)*BIT_PERIOD.
  - With BIT_PERIOD=1, shift_out is high for WIDTH consecutive cycles.
- Completion: done=1, busy=0, ready=1 in cycle WIDTH*BIT_PERIOD+1. serial_out returns to 0 in IDLE.
- Back-to-back: a load asserted in the done cycle is accepted. The next word's MSB appears in the following cycle, with no idle gap beyond that one cycle.
- Loads while busy are ignored; data_in is not sampled and no error is flagged. data_in may change freely after acceptance.
- clear asserted mid-frame aborts immediately. No done pulse is generated, and the partial word is discarded. After release the block is in IDLE with ready=1.
- shift_out is never high in IDLE and is never high for two consecutive cycles when BIT_PERIOD>1.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined: after the WIDTH data bits, one extra bit period sends even parity (XOR reduction of the accepted word) with its own shift_out strobe. done moves to cycle (WIDTH+1)*BIT_PERIOD+1. The receiver must then be WIDTH+1 bits wide.
- Undefined: no parity bit; timing exactly as in Behaviour.

Decomposition:
- Shared package (piso_tx_pkg): state typedef {IDLE, SHIFT}, default WIDTH/BIT_PERIOD constants, and the counter-width function clog2.
- One natural sub-module: bit_period_timer, a modulo-BIT_PERIOD counter producing a tick that becomes shift_out. When BIT_PERIOD=1 it degenerates to a constant tick. The FSM and shift register stay in the top module.

Test Plan:
- Reset mid-frame: load 8'hA5, assert clear in cycle 3 -> all outputs 0 immediately, ready=1; no done pulse; after release, load 8'h3C -> 3C delivered normally.
- Basic word, BIT_PERIOD=1: load 8'hA5 -> serial_out 1,0,1,0,0,1,0,1 in cycles 1-8; shift_out high in cycles 1-8; done in cycle 9; loopback receiver out=8'hA5.
- BIT_PERIOD=3: load 8'h81 -> each bit held 3 cycles; shift_out high only in cycles 3,6,...,24; done in cycle 25; receiver=8'h81.
- Busy rejection: load 8'hFF, then pulse load with 8'h00 in cycle 4 -> ignored; receiver=8'hFF; exactly 8 strobes.
- Back-to-back: load 8'h0F, hold load with 8'hF0 in the done cycle -> accepted; receiver sees 0F then F0; one non-strobe cycle between frames.
- PISO_TX_PARITY_EN defined: load 8'h07 -> ninth strobed bit=1; done in cycle 10; load 8'h03 -> parity bit 0.
